// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
//   Round-robin front end for one shared, registered WIDTH-bit adder. Each
//   cycle at most one requester is granted; its operands are steered to the
//   adder and its index rides a tag pipeline matched to the adder latency so
//   every result comes back tagged with the requester that issued it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   hold                suppress new grants (in-flight work still drains)
//   req_valid[NREQ]     per-requester request
//   req_a/req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ci[NREQ]        per-requester carry-in
//   req_ready[NREQ]     one-hot grant (or zero)
//   add_a/add_b/add_ci  operands to the shared adder
//   add_s/add_co        registered sum/carry from the shared adder
//   rsp_valid/rsp_id    result strobe and owning requester
//   rsp_s/rsp_co        result sum/carry (pass-through from the adder)
//   busy                any operation in flight
module adder_rr_scheduler #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int ADDER_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_ci,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_ci,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_co,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_co,
  output logic                  busy
);

  logic [IDW-1:0]       r_last_grant;
  logic [ADDER_LAT-1:0] r_vld_p;
  logic [IDW-1:0]       r_id_p [ADDER_LAT];

  logic                 w_found;
  logic [IDW-1:0]       w_gnt_idx;
  logic [IDW-1:0]       w_scan_idx;
  logic [NREQ-1:0]      w_grant;

  // Arbitration: scan starting just after the last grant so the most recently
  // served requester is considered last. Reset forces the grant off because
  // req_ready must read zero while rst is high.
  always_comb begin
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    w_grant    = '0;
    if (!rst && !hold) begin
      for (int off = 1; off <= NREQ; off++) begin
        w_scan_idx = IDW'((int'(r_last_grant) + off) % NREQ);
        if (!w_found && req_valid[w_scan_idx]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_scan_idx;
        end
      end
    end
    if (w_found) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant;

  // Operand mux: the grant is one-hot or zero, so an OR of gated operands
  // selects the winner and yields zero when nobody is granted.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        add_a  = add_a | req_a[i*WIDTH +: WIDTH];
        add_b  = add_b | req_b[i*WIDTH +: WIDTH];
        add_ci = add_ci | req_ci[i];
      end
    end
  end

  // Stage p0 captures the tag of the operation issued this edge; the last
  // stage lines up with the adder's registered outputs. Reset drops every
  // in-flight tag, so stale adder results are never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_vld_p      <= '0;
      for (int i = 0; i < ADDER_LAT; i++) begin
        r_id_p[i] <= '0;
      end
    end else begin
      if (w_found) begin
        r_last_grant <= w_gnt_idx;
      end
      r_vld_p[0] <= w_found;
      r_id_p[0]  <= w_found ? w_gnt_idx : '0;
      for (int i = 1; i < ADDER_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_id_p[i]  <= r_id_p[i-1];
      end
    end
  end

  // Final tag stage: response strobe and owner.
  assign rsp_valid = r_vld_p[ADDER_LAT-1];
  assign rsp_id    = r_id_p[ADDER_LAT-1];
  assign rsp_s     = add_s;
  assign rsp_co    = add_co;
  assign busy      = |r_vld_p;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hold;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ci;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_ci;
  logic [WIDTH-1:0]      add_s;
  logic                  add_co;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_s;
  logic                  rsp_co;
  logic                  busy;

  always #5 clk = ~clk;

  adder_rr_scheduler #(
    .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .ADDER_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co),
    .busy(busy)
  );

  // Shared adder stand-in: registered sum/carry after LAT clocks.
  logic [WIDTH:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_s  = apipe[LAT-1][WIDTH-1:0];
  assign add_co = apipe[LAT-1][WIDTH];

  // Reference model state
  typedef struct {
    int               due;
    int               id;
    logic [WIDTH-1:0] s;
    logic             co;
  } rsp_t;

  rsp_t q[$];
  rsp_t rseq[$];
  int   gseq[$];
  int   mlast;
  int   cyc;
  int   obs_busy;
  int   vectors;
  int   miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst || hold) return -1;
    for (int off = 1; off <= NREQ; off++) begin
      if (req_valid[(mlast + off) % NREQ]) return (mlast + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(0, 3))
        0:       req_a[i*WIDTH +: WIDTH] = '1;
        1:       req_a[i*WIDTH +: WIDTH] = '0;
        default: req_a[i*WIDTH +: WIDTH] = $urandom;
      endcase
      req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
      req_ci[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int             g;
    int             og;
    int             ones;
    logic [WIDTH:0] sum;
    logic           ev;
    rsp_t           e;
    @(negedge clk);
    if (rst) begin
      q.delete();
      mlast = NREQ - 1;
    end
    g = model_grant();
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    if (g >= 0) begin
      chk("add_a", 64'(add_a), 64'(req_a[g*WIDTH +: WIDTH]));
      chk("add_b", 64'(add_b), 64'(req_b[g*WIDTH +: WIDTH]));
      chk("add_ci", 64'(add_ci), 64'(req_ci[g]));
    end else begin
      chk("add_idle", {31'd0, add_ci, add_a}, 64'd0);
    end
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (rst) chk("rsp_id_rst", 64'(rsp_id), 64'd0);
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_s", 64'(rsp_s), 64'(q[0].s));
      chk("rsp_co", 64'(rsp_co), 64'(q[0].co));
      void'(q.pop_front());
    end
    // observation log for directed scenario checks
    ones = 0;
    og = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) begin ones++; og = i; end
    gseq.push_back((ones > 1) ? -2 : og);
    if (rsp_valid === 1'b1) begin
      e.due = cyc; e.id = int'(rsp_id); e.s = rsp_s; e.co = rsp_co;
      rseq.push_back(e);
    end
    obs_busy = int'(busy);
    @(posedge clk);
    if (!rst && g >= 0) begin
      sum   = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]}
            + {{WIDTH{1'b0}}, req_ci[g]};
      mlast = g;
      e.due = cyc + LAT; e.id = g; e.s = sum[WIDTH-1:0]; e.co = sum[WIDTH];
      q.push_back(e);
    end
    if (rst) begin
      q.delete();
      mlast = NREQ - 1;
    end
    cyc++;
    #1;
  endtask

  task automatic chk_gseq(input string tag, input int exp[]);
    chk({tag, "_len"}, 64'(gseq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < gseq.size(); i++) chk(tag, 64'(gseq[i]), 64'(exp[i]));
  endtask

  initial begin
    int e3[];
    int e4[];
    int e5[];
    vectors = 0; miscompares = 0; cyc = 0; mlast = NREQ - 1;
    rst = 1'b1; hold = 1'b0; req_valid = '1;
    rand_ops();

    // Reset with every requester asking: nothing granted, nothing returned.
    repeat (2) step();
    rst = 1'b0;
    gseq.delete();
    step();
    chk("first_grant", 64'(gseq[0]), 64'd0);
    req_valid = '0;
    repeat (LAT) step();

    // Single op from requester 2 that wraps to zero with carry-out.
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    req_b[2*WIDTH +: WIDTH] = 32'd1;
    req_ci[2] = 1'b0;
    rseq.delete();
    step();
    req_valid = '0;
    repeat (LAT) step();
    chk("single_cnt", 64'(rseq.size()), 64'd1);
    if (rseq.size() > 0) begin
      chk("single_id", 64'(rseq[0].id), 64'd2);
      chk("single_s", 64'(rseq[0].s), 64'd0);
      chk("single_co", 64'(rseq[0].co), 64'd1);
    end

    // All four requesting for eight cycles: strict rotation from after 2.
    req_valid = '1;
    gseq.delete(); rseq.delete();
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (LAT) step();
    e3 = '{3, 0, 1, 2, 3, 0, 1, 2};
    gseq = gseq[0:7];
    chk_gseq("rot_grant", e3);
    chk("rot_rsp_cnt", 64'(rseq.size()), 64'd8);
    for (int i = 0; i < 8 && i < rseq.size(); i++) chk("rot_rsp_id", 64'(rseq[i].id), 64'(e3[i]));

    // Requesters 1 and 3; 3 drops after its first grant.
    gseq.delete();
    req_valid = 4'b0010; rand_ops(); step();
    req_valid = 4'b1010; rand_ops(); step();
    req_valid = 4'b0010; rand_ops(); step();
    rand_ops(); step();
    req_valid = '0;
    e4 = '{1, 3, 1, 1};
    gseq = gseq[0:3];
    chk_gseq("drop_grant", e4);
    repeat (LAT) step();

    // Hold mid-stream: in-flight results drain, rotation resumes after hold.
    gseq.delete(); rseq.delete();
    req_valid = '1;
    repeat (4) begin rand_ops(); step(); end
    hold = 1'b1;
    repeat (3) begin rand_ops(); step(); end
    chk("hold_rsp_cnt", 64'(rseq.size()), 64'd4);
    hold = 1'b0;
    rand_ops(); step();
    chk("hold_busy_drained", 64'(obs_busy), 64'd0);
    e5 = '{2, 3, 0, 1, -1, -1, -1, 2};
    chk_gseq("hold_grant", e5);

    // Reset with two operations in flight: both are discarded.
    rand_ops(); step();
    rseq.delete();
    rst = 1'b1; step();
    rst = 1'b0; req_valid = '0;
    repeat (LAT) step();
    chk("rst_no_rsp", 64'(rseq.size()), 64'd0);
    chk("rst_busy", 64'(obs_busy), 64'd0);
    req_valid = '1; gseq.delete();
    step();
    chk("rst_first_grant", 64'(gseq[0]), 64'd0);

    // Randomised traffic with occasional hold and reset.
    repeat (300) begin
      req_valid = NREQ'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      rand_ops();
      step();
      rst = 1'b0;
    end
    hold = 1'b0; req_valid = '0;
    repeat (LAT + 1) step();
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Round-robin scheduler that shares one registered 32-bit adder among NREQ requesters.
- The shared adder has a fixed latency of ADDER_LAT clocks from operand to registered sum and carry.
- Each cycle the scheduler grants at most one requester and drives that requester's operands to the adder. It tracks the requester ID through the adder pipeline and returns each result tagged with its originating requester.
- Sits between the requester front-ends and the shared adder instance (adder_behavior_reg or equivalent).

Parameters:
- WIDTH, 32, operand and sum width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).
- ADDER_LAT, 1, clocks from add_a/add_b/add_ci to valid add_s/add_co (1..4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  when 1, no new grant is issued; in-flight operations still complete.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, packed the same way as req_a.
- req_ci  input  NREQ  per-requester carry-in.
- req_ready  output  NREQ  one-hot grant; the request is accepted when req_valid[i] && req_ready[i].
- add_a  output  WIDTH  operand A to the shared adder.
- add_b  output  WIDTH  operand B to the shared adder.
- add_ci  output  1  carry-in to the shared adder.
- add_s  input  WIDTH  registered sum returned from the shared adder.
- add_co  input  1  registered carry-out returned from the shared adder.
- rsp_valid  output  1  result valid, single-cycle pulse per accepted request.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_s  output  WIDTH  result sum.
- rsp_co  output  1  result carry-out.
- busy  output  1  high while any operation is in flight.

Behaviour:
- Reset is asynchronous, active-high (rst), on clock clk.
- Values while rst is high:
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, busy = 0.
  - All tag-pipeline stages invalid.
  - Priority pointer last_grant = NREQ-1, so requester 0 has highest priority after reset.
- Arbitration (combinational, every cycle):
  - If hold = 1, or no req_valid is set, req_ready = 0.
  - Otherwise grant the first i with req_valid[i] = 1, scanning last_grant+1, last_grant+2, … modulo NREQ.
  - req_ready is one-hot or zero. It never depends on rsp state, so the adder issues at most one operation per cycle at full throughput.
- Operand mux:
  - add_a/add_b/add_ci = granted requester's operands.
  - With no grant, they are driven to 0.
- Issue: on a clock edge with a grant to index g:
  - last_grant <= g.
  - Push {valid=1, id=g} into the tag pipeline.
  - Without a grant, push {valid=0, id=0}.
  - last_grant is unchanged when there is no grant.
- Tag pipeline:
  - ADDER_LAT stages, shifted every clock, never stalls.
  - Stage ADDER_LAT-1 aligns with add_s/add_co.
- Response:
  - rsp_valid = valid of the final tag stage; rsp_id = id of the final tag stage.
  - rsp_s = add_s, rsp_co = add_co (pass-through).
  - rsp_s/rsp_co are meaningful only when rsp_valid = 1.
  - Latency: an operation accepted at edge k produces rsp_valid during the cycle after edge k+ADDER_LAT-1, i.e. ADDER_LAT cycles after acceptance.
  - Responses are in acceptance order; there is no response backpressure.
- busy = OR of all tag-stage valid bits.
- Arithmetic: none in this block. A WIDTH-bit sum with carry-out (mod 2^WIDTH) is produced by the adder; operands pass unmodified.
- Boundary conditions:
  - A requester holding req_valid continuously is re-granted only after every other active requester has been granted once. Worst-case wait is NREQ-1 cycles.
  - Single active requester: granted every cycle.
  - hold rising mid-stream: no new grants from that cycle; in-flight results still emerge; last_grant is kept, so fairness resumes where it stopped.
  - req_valid dropping without acceptance: no effect on state.
  - rst asserted mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. Adder outputs seen after reset are ignored until new grants propagate.

Test Plan:
- Reset → rst=1 with all req_valid=1: req_ready=0 and rsp_valid=0. After release, first grant is req_ready=4'b0001.
- Single op, ADDER_LAT=1, requester 2: a=32'hFFFF_FFFF, b=1, ci=0 → one cycle later rsp_valid=1, rsp_id=2, rsp_s=0, rsp_co=1.
- All four requesters valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Responses: eight rsp_valid pulses with rsp_id in the same order, ADDER_LAT cycles delayed.
- Requesters 1 and 3 valid, 3 drops after its first grant → grants 1,3,1,1; rsp_id order matches.
- hold=1 for 3 cycles during a stream with ADDER_LAT=3 → req_ready=0 during hold. The three already-accepted ops still return, and busy falls to 0. After hold releases, the grant resumes at last_grant+1.
- rst pulse while 2 ops are in flight (ADDER_LAT=2) → neither op produces rsp_valid, busy=0, and the next grant goes to requester 0 first.
